// File: rtl/pc_unit.sv
// Fetch-stage PC register and next-PC selector for the MIPS branch/jump set.
// Optional return-address stack is enabled with `define PC_UNIT_RAS_EN.
module pc_unit #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_PC    = WIDTH'(32'h0000_4180),
    parameter int unsigned       RAS_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       npc_sel,
    input  logic             zero,
    input  logic [25:0]      imme,
    input  logic [WIDTH-1:0] rs,
    input  logic             ras_hint,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_4,
    output logic [WIDTH-1:0] npc,
    output logic             taken,
    output logic             link,
    output logic             err,
    output logic             ras_mismatch
);

    typedef enum logic [3:0] {
        SEL_SEQ  = 4'd0,
        SEL_BEQ  = 4'd1,
        SEL_BNE  = 4'd2,
        SEL_BLEZ = 4'd3,
        SEL_BGTZ = 4'd4,
        SEL_BLTZ = 4'd5,
        SEL_BGEZ = 4'd6,
        SEL_J    = 4'd7,
        SEL_JAL  = 4'd8,
        SEL_JR   = 4'd9,
        SEL_JALR = 4'd10
    } npc_sel_e;

    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] j_tgt;
    logic             rs_neg;
    logic             rs_zero;
    logic             misalign;

    assign pc_4    = pc + {{(WIDTH-3){1'b0}}, 3'd4};
    assign br_tgt  = pc_4 + {{(WIDTH-18){imme[15]}}, imme[15:0], 2'b00};
    assign j_tgt   = {pc[WIDTH-1:28], imme, 2'b00};
    assign rs_neg  = rs[WIDTH-1];
    assign rs_zero = (rs == '0);
    assign link    = (npc_sel == SEL_JAL) || (npc_sel == SEL_JALR);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        npc      = pc_4;
        taken    = 1'b0;
        misalign = 1'b0;
        case (npc_sel)
            SEL_BEQ:  taken = zero;
            SEL_BNE:  taken = !zero;
            SEL_BLEZ: taken = rs_neg | rs_zero;
            SEL_BGTZ: taken = !rs_neg & !rs_zero;
            SEL_BLTZ: taken = rs_neg;
            SEL_BGEZ: taken = !rs_neg;
            SEL_J, SEL_JAL: begin
                taken = 1'b1;
                npc   = j_tgt;
            end
            SEL_JR, SEL_JALR: begin
                taken = 1'b1;
                if (rs[1:0] != 2'b00) begin
                    misalign = 1'b1;
                    npc      = EXC_PC;
                end else begin
                    npc = rs;
                end
            end
            default: ;
        endcase
        // Conditional branches only override the sequential path when taken.
        if (taken && npc_sel inside {SEL_BEQ, SEL_BNE, SEL_BLEZ, SEL_BGTZ, SEL_BLTZ, SEL_BGEZ})
            npc = br_tgt;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= RESET_PC;
            err <= 1'b0;
        end else if (en) begin
            pc  <= npc;
            err <= err | misalign;
        end
    end

`ifdef PC_UNIT_RAS_EN
    localparam int unsigned AW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [AW-1:0]    ras_sp;
    logic [AW:0]      ras_cnt;
    logic [WIDTH-1:0] ras_top;
    logic             ras_ret;

    assign ras_top      = ras_mem[ras_sp - AW'(1)];
    assign ras_ret      = (npc_sel == SEL_JR) && ras_hint && (ras_cnt != '0);
    assign ras_mismatch = ras_ret && (ras_top != rs);

    // Pointer always advances on push; the count saturates so the oldest entry is overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            ras_sp  <= '0;
            ras_cnt <= '0;
        end else if (en) begin
            if (link) begin
                ras_sp <= ras_sp + AW'(1);
                if (ras_cnt != (AW+1)'(RAS_DEPTH))
                    ras_cnt <= ras_cnt + (AW+1)'(1);
            end else if (ras_ret) begin
                ras_sp  <= ras_sp - AW'(1);
                ras_cnt <= ras_cnt - (AW+1)'(1);
            end
        end
    end

    // NOTE: stack storage is not reset; the count alone marks entries as valid.
    always_ff @(posedge clk) begin
        if (!reset && en && link)
            ras_mem[ras_sp] <= pc_4;
    end
`else
    wire unused_ras = ras_hint ^ (RAS_DEPTH == 0);
    assign ras_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a driver pushes expected outputs from a
// behavioural model, a monitor pops and compares them every cycle.
module tb_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset, en, zero, ras_hint;
    logic [3:0]  npc_sel;
    logic [25:0] imme;
    logic [31:0] rs;
    logic [31:0] pc, pc_4, npc;
    logic        taken, link, err, ras_mismatch;

    always #5 clk = ~clk;

    pc_unit #(
        .WIDTH    (32),
        .RESET_PC (RESET_PC),
        .EXC_PC   (EXC_PC),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .npc_sel     (npc_sel),
        .zero        (zero),
        .imme        (imme),
        .rs          (rs),
        .ras_hint    (ras_hint),
        .pc          (pc),
        .pc_4        (pc_4),
        .npc         (npc),
        .taken       (taken),
        .link        (link),
        .err         (err),
        .ras_mismatch(ras_mismatch)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_4;
        logic [31:0] npc;
        logic        taken;
        logic        link;
        logic        err;
        logic        rasm;
    } exp_t;

    exp_t sb[$];
    int   tests    = 0;
    int   failures = 0;

    // Reference state: architectural PC, sticky error, and the return stack as a queue.
    logic [31:0] m_pc;
    logic        m_err;
    logic [31:0] m_stack[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are stable by the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("pc",           pc,                  e.pc);
            check("pc_4",         pc_4,                e.pc_4);
            check("npc",          npc,                 e.npc);
            check("taken",        32'(taken),          32'(e.taken));
            check("link",         32'(link),           32'(e.link));
            check("err",          32'(err),            32'(e.err));
            check("ras_mismatch", 32'(ras_mismatch),   32'(e.rasm));
        end
    end

    function automatic exp_t model(input int sel, input logic z, input logic [25:0] im,
                                   input logic [31:0] r, input logic h);
        exp_t        e;
        logic [15:0] off;
        logic [31:0] br;
        bit          cond;
        off     = im[15:0];
        e.pc    = m_pc;
        e.pc_4  = m_pc + 32'd4;
        br      = e.pc_4 + 32'($signed(off)) * 32'd4;
        e.err   = m_err;
        e.link  = (sel == 8) || (sel == 10);
        e.npc   = e.pc_4;
        e.taken = 1'b0;
        cond    = 1'b0;
        case (sel)
            1: cond = z;
            2: cond = !z;
            3: cond = $signed(r) <= 0;
            4: cond = $signed(r) > 0;
            5: cond = $signed(r) < 0;
            6: cond = $signed(r) >= 0;
            default: ;
        endcase
        if (sel >= 1 && sel <= 6 && cond) begin
            e.npc   = br;
            e.taken = 1'b1;
        end else if (sel == 7 || sel == 8) begin
            e.npc   = (m_pc & 32'hF000_0000) + {4'h0, im, 2'b00};
            e.taken = 1'b1;
        end else if (sel == 9 || sel == 10) begin
            e.npc   = (r % 4 != 0) ? EXC_PC : r;
            e.taken = 1'b1;
        end
`ifdef PC_UNIT_RAS_EN
        e.rasm = (sel == 9) && h && (m_stack.size() > 0) && (m_stack[$] != r);
`else
        e.rasm = 1'b0;
`endif
        return e;
    endfunction

    task automatic step(input int sel, input logic z, input logic [25:0] im, input logic [31:0] r,
                        input logic h, input logic e, input logic rst);
        exp_t x;
        npc_sel  = 4'(sel);
        zero     = z;
        imme     = im;
        rs       = r;
        ras_hint = h;
        en       = e;
        reset    = rst;
        x = model(sel, z, im, r, h);
        sb.push_back(x);
        @(posedge clk);
        if (rst) begin
            m_pc  = RESET_PC;
            m_err = 1'b0;
            m_stack.delete();
        end else if (e) begin
            m_pc  = x.npc;
            m_err = m_err | ((sel == 9 || sel == 10) && (r % 4 != 0));
            if (x.link) begin
                m_stack.push_back(x.pc_4);
                if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
            end else if (sel == 9 && h && m_stack.size() > 0) begin
                void'(m_stack.pop_back());
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; npc_sel = '0; zero = 1'b0;
        imme = '0; rs = '0; ras_hint = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_pc  = RESET_PC;
        m_err = 1'b0;

        // Sequential fetch from reset, then BEQ backwards (stalled) and fall-through.
        repeat (4) step(0, 0, 26'h0, 32'h0, 0, 1, 0);
        step(1, 1, 26'h000FFFE, 32'h0, 0, 0, 0);
        step(1, 0, 26'h000FFFE, 32'h0, 0, 1, 0);
        // Sign-based branches on zero and most-negative rs.
        step(3, 0, 26'h10, 32'h0000_0000, 0, 0, 0);
        step(4, 0, 26'h10, 32'h0000_0000, 0, 0, 0);
        step(5, 0, 26'h10, 32'h8000_0000, 0, 0, 0);
        step(6, 0, 26'h10, 32'h8000_0000, 0, 0, 0);
        step(4, 0, 26'h10, 32'h0000_0001, 0, 1, 0);
        // JAL from reset PC, misaligned JR trap, sticky err.
        step(0, 0, 26'h0, 32'h0, 0, 1, 1);
        step(8, 0, 26'h0000C10, 32'h0, 0, 1, 0);
        step(9, 0, 26'h0, 32'h0000_3006, 0, 1, 0);
        repeat (5) step(0, 0, 26'h0, 32'h0, 0, 1, 0);
        // Stall with J selected, then reset during stall.
        repeat (4) step(7, 0, 26'h0123456, 32'h0, 0, 0, 0);
        step(7, 0, 26'h0123456, 32'h0, 0, 0, 1);
        // Wrap from top of the address space.
        step(9, 0, 26'h0, 32'hFFFF_FFFC, 0, 1, 0);
        step(0, 0, 26'h0, 32'h0, 0, 1, 0);
        step(0, 0, 26'h0, 32'h0, 0, 1, 0);
        // Return stack: three calls into a two-deep stack, then returns.
        step(0, 0, 26'h0, 32'h0, 0, 1, 1);
        step(8, 0, 26'h0001000, 32'h0, 0, 1, 0);
        step(8, 0, 26'h0001400, 32'h0, 0, 1, 0);
        step(8, 0, 26'h0001800, 32'h0, 0, 1, 0);
        step(9, 0, 26'h0, 32'h0000_5004, 1, 1, 0);
        step(9, 0, 26'h0, 32'h9999_9990, 1, 1, 0);
        step(9, 0, 26'h0, 32'h0000_1000, 1, 1, 0);
        step(9, 0, 26'h0, 32'h0000_2000, 1, 1, 0);
        // JALR with hint pushes only.
        step(10, 0, 26'h0, 32'h0000_3000, 1, 1, 0);
        step(9, 0, 26'h0, 32'h0000_3010, 1, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            int          s;
            logic [31:0] r;
            s = int'($urandom_range(15));
            r = $urandom;
            if ($urandom_range(3) != 0) r[1:0] = 2'b00;
            if (s == 9 && m_stack.size() > 0 && $urandom_range(1) == 1) r = m_stack[$];
            step(s, 1'($urandom), 26'($urandom), r, 1'($urandom),
                 $urandom_range(4) != 0, $urandom_range(49) == 0);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the combinational next-PC calculator.
- Owns the architectural PC register and computes the next fetch address from the full MIPS branch/jump set, including link and stall.
- Traps misaligned register-jump targets to an exception vector and keeps a sticky error flag.
- Sits at the head of the fetch stage: it feeds the instruction memory address and the link value to GRF write-back.

Parameters:
- WIDTH, 32: PC/data width; legal range 32..64.
- RESET_PC, 32'h0000_3000: PC value after reset.
- EXC_PC, 32'h0000_4180: PC loaded on a misaligned JR/JALR target.
- RAS_DEPTH, 8: return-address-stack entries; power of 2, 2..64. Used only with RAS_EN.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- en, input, 1: PC update enable; 0 = stall.
- npc_sel, input, 4: instruction class (encoding below).
- zero, input, 1: rs == rt, from the ALU/comparator.
- imme, input, 26: instr[25:0]; offset is imme[15:0].
- rs, input, WIDTH: $rs data.
- ras_hint, input, 1: current JR is a return (rs field == 31). Ignored without RAS_EN.
- pc, output, WIDTH: current PC (register).
- pc_4, output, WIDTH: pc + 4; also the link value for JAL/JALR.
- npc, output, WIDTH: next PC (combinational).
- taken, output, 1: non-sequential target selected this cycle.
- link, output, 1: current instruction is JAL or JALR.
- err, output, 1: sticky misaligned-target flag.
- ras_mismatch, output, 1: return-prediction miss pulse. Tied to 0 without RAS_EN.

Behaviour:
- npc_sel encoding: 0 SEQ, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 J, 8 JAL, 9 JR, 10 JALR. Codes 11-15 behave as SEQ.
- Branch target: pc_4 + (sign-extended offset << 2), modulo 2^WIDTH.
- Jump target: {pc[WIDTH-1:28], imme, 2'b00}.
- Register target: rs.
- Branch conditions:
  - BEQ: zero. BNE: !zero.
  - BLEZ: rs[WIDTH-1] | (rs==0).
  - BGTZ: !rs[WIDTH-1] & (rs!=0).
  - BLTZ: rs[WIDTH-1]. BGEZ: !rs[WIDTH-1].
- npc selection:
  - Branch with condition true: branch target.
  - Branch with condition false: pc_4.
  - J, JAL: jump target.
  - JR, JALR with rs[1:0]==0: rs.
  - JR, JALR with rs[1:0]!=0: EXC_PC.
  - Otherwise: pc_4.
- taken = 1 whenever npc != pc_4 by selection, not by value equality.
- link = (npc_sel == 8 or 10), independent of en.
- Clocked update, rising edge:
  - reset: pc <= RESET_PC, err <= 0, RAS cleared.
  - else if en: pc <= npc; err <= err | (register jump with rs[1:0]!=0).
  - else (stall): pc, err and RAS unchanged.
- Latency: npc, pc_4, taken and link are combinational from pc and inputs in the same cycle. pc reflects npc one cycle later.
- Reset mid-stall: reset wins over en.
- err clears only on reset.
- No delay slot: link value is pc + 4.
- Wrap: pc = max value - 3 plus SEQ wraps to 0 without error.

Optional Feature:
- Macro: PC_UNIT_RAS_EN.
- Enabled: a RAS_DEPTH-entry circular return-address stack, updated only when en=1 and reset=0.
  - JAL/JALR push pc_4.
  - JR with ras_hint=1 pops.
  - ras_mismatch = 1 combinationally when JR & ras_hint & stack non-empty & top != rs.
  - Pop on empty: no pointer change, ras_mismatch = 0.
  - Push when full: overwrites the oldest entry (pointer wraps); count saturates at RAS_DEPTH.
  - JALR with ras_hint: push only.
  - The stack never alters npc.
- Disabled: no stack storage, ras_hint ignored, ras_mismatch tied 0.

Test Plan:
1. Reset then 3 cycles en=1, SEQ -> pc = 0x3000, 0x3004, 0x3008, 0x300C; taken=0; err=0.
2. pc=0x3010, BEQ, zero=1, imme[15:0]=0xFFFE -> npc=0x300C, taken=1. Same with zero=0 -> npc=0x3014.
3. rs=0x0000_0000: BLEZ taken, BGTZ not taken. rs=0x8000_0000: BLTZ taken, BGEZ not taken.
4. pc=0x3000, JAL, imme=0x0000C10 -> npc=0x0000_3040, link=1, pc_4=0x3004. Then JR rs=0x3006 -> npc=0x4180, err=1 after the edge and still 1 after 5 SEQ cycles.
5. en=0 for 4 cycles with J selected -> pc held. Assert reset while en=0 -> pc=0x3000 next edge.
6. (RAS_EN, RAS_DEPTH=2) Three JALs from 0x3000/0x4000/0x5000, then JR hint rs=0x5004 -> ras_mismatch=0. Then JR hint rs=0x9999_9990 -> ras_mismatch=1. Then JR hint -> ras_mismatch=0, stack empty.
